// File: rtl/llc_lookup_ctrl_pkg.sv
// Shared types, constants and FSM state encoding for the LLC lookup controller
// and its way selector.
package llc_lookup_ctrl_pkg;

    localparam int NUM_PORTS    = 16;
    localparam int SET_BITS     = 8;
    localparam int TAG_BITS     = 12;
    localparam int WAY_BITS     = $clog2(NUM_PORTS);
    localparam int LINE_BITS    = 64;
    localparam int STATE_BITS   = 3;
    localparam int SHARERS_BITS = 16;
    localparam int OWNER_BITS   = 4;
    localparam int HPROT_BITS   = 2;

    typedef logic [SET_BITS-1:0]          llc_set_t;
    typedef logic [TAG_BITS-1:0]          llc_tag_t;
    typedef logic [WAY_BITS-1:0]          llc_way_t;
    typedef logic [SET_BITS+WAY_BITS-1:0] llc_addr_t;
    typedef logic [STATE_BITS-1:0]        llc_state_t;
    typedef logic [LINE_BITS-1:0]         line_t;
    typedef logic [SHARERS_BITS-1:0]      sharers_t;
    typedef logic [OWNER_BITS-1:0]        owner_t;
    typedef logic [HPROT_BITS-1:0]        hprot_t;

    localparam llc_state_t INVALID = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_CMP,
        ST_RESP,
        ST_UPD
    } lookup_state_e;

endpackage

// File: rtl/llc_way_select.sv
// Combinational way selection: lowest-index valid tag match, else lowest-index
// INVALID way, else the memory-supplied eviction way.
module llc_way_select
    import llc_lookup_ctrl_pkg::*;
#(
    parameter int NUM_WAYS = NUM_PORTS
) (
    input  llc_tag_t   req_tag_i,
    input  llc_tag_t   way_tag_i   [NUM_WAYS],
    input  llc_state_t way_state_i [NUM_WAYS],
    input  llc_way_t   evict_way_i,
    output logic       hit_o,
    output llc_way_t   way_o,
    output llc_state_t state_o
);

    logic [NUM_WAYS-1:0] match;
    logic [NUM_WAYS-1:0] invalid;

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign invalid[gi] = (way_state_i[gi] == INVALID);
            assign match[gi]   = !invalid[gi] && (way_tag_i[gi] == req_tag_i);
        end
    endgenerate

    // Descending scans so the lowest qualifying index is the last one written.
    always_comb begin
        hit_o   = |match;
        way_o   = evict_way_i;
        state_o = '0;
        if (|match) begin
            for (int i = NUM_WAYS - 1; i >= 0; i--) begin
                if (match[i]) way_o = llc_way_t'(i);
            end
        end else if (|invalid) begin
            for (int i = NUM_WAYS - 1; i >= 0; i--) begin
                if (invalid[i]) way_o = llc_way_t'(i);
            end
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (way_o == llc_way_t'(i)) state_o = way_state_i[i];
        end
    end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// LLC lookup controller: one lookup per set, parallel way read and tag compare,
// then holds the set until the requester's update beats are written.
// Optional hit/miss counters are enabled with LLC_LOOKUP_STATS_EN.
module llc_lookup_ctrl
    import llc_lookup_ctrl_pkg::*;
#(
    parameter int NUM_WAYS   = NUM_PORTS,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  llc_set_t    req_set,
    input  llc_tag_t    req_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_hit,
    output llc_way_t    rsp_way,
    output llc_state_t  rsp_state,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic        upd_we,
    input  logic        upd_last,
    input  llc_way_t    upd_way,
    input  llc_tag_t    upd_tag,
    input  line_t       upd_line,
    input  llc_state_t  upd_state,
    input  sharers_t    upd_sharers,
    input  owner_t      upd_owner,
    input  hprot_t      upd_hprot,
    input  logic        upd_dirty_bit,
    output llc_set_t    mem_rd_set,
    output logic        mem_rd_en,
    input  llc_tag_t    mem_rd_data_tag       [NUM_WAYS],
    input  llc_state_t  mem_rd_data_state     [NUM_WAYS],
    input  llc_way_t    mem_rd_data_evict_way [NUM_WAYS],
`ifdef LLC_LOOKUP_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    output llc_addr_t   mem_wr_addr,
    output logic        mem_wr_en,
    output line_t       mem_wr_data_line,
    output llc_tag_t    mem_wr_data_tag,
    output sharers_t    mem_wr_data_sharers,
    output owner_t      mem_wr_data_owner,
    output hprot_t      mem_wr_data_hprot,
    output logic        mem_wr_data_dirty_bit,
    output llc_way_t    mem_wr_data_evict_way,
    output llc_state_t  mem_wr_data_state
);

    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    lookup_state_e     state_q;
    llc_set_t          set_q;
    llc_tag_t          tag_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              req_ready_q, rsp_valid_q, upd_ready_q, mem_rd_en_q, mem_wr_en_q;
    logic              rsp_hit_q;
    llc_way_t          rsp_way_q, evict0_q, wr_evict_q, wr_evict_d;
    llc_state_t        rsp_state_q, wr_state_q;
    llc_addr_t         wr_addr_q;
    line_t             wr_line_q;
    llc_tag_t          wr_tag_q;
    sharers_t          wr_sharers_q;
    owner_t            wr_owner_q;
    hprot_t            wr_hprot_q;
    logic              wr_dirty_q;

    logic              sel_hit;
    llc_way_t          sel_way;
    llc_state_t        sel_state;

    llc_way_select #(.NUM_WAYS(NUM_WAYS)) u_way_select (
        .req_tag_i   (tag_q),
        .way_tag_i   (mem_rd_data_tag),
        .way_state_i (mem_rd_data_state),
        .evict_way_i (mem_rd_data_evict_way[0]),
        .hit_o       (sel_hit),
        .way_o       (sel_way),
        .state_o     (sel_state)
    );

    // Only way 0 carries the set's eviction pointer; the other lanes are ignored.
    logic [NUM_WAYS*WAY_BITS-1:0] evict_flat;
    logic                         unused_evict_ways;
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_evict_flat
            assign evict_flat[gi*WAY_BITS +: WAY_BITS] = mem_rd_data_evict_way[gi];
        end
    endgenerate
    assign unused_evict_ways = ^evict_flat;

    // Filling the victim of a miss advances the round-robin eviction pointer.
    always_comb begin
        wr_evict_d = evict0_q;
        if (!rsp_hit_q && (upd_way == rsp_way_q)) begin
            wr_evict_d = (rsp_way_q == llc_way_t'(NUM_WAYS - 1)) ? '0 : llc_way_t'(rsp_way_q + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            set_q        <= '0;
            tag_q        <= '0;
            wait_cnt_q   <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            upd_ready_q  <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_state_q  <= '0;
            evict0_q     <= '0;
            wr_addr_q    <= '0;
            wr_line_q    <= '0;
            wr_tag_q     <= '0;
            wr_sharers_q <= '0;
            wr_owner_q   <= '0;
            wr_hprot_q   <= '0;
            wr_dirty_q   <= 1'b0;
            wr_evict_q   <= '0;
            wr_state_q   <= '0;
        end else begin
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        set_q       <= req_set;
                        tag_q       <= req_tag;
                        req_ready_q <= 1'b0;
                        mem_rd_en_q <= 1'b1;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    wait_cnt_q <= '0;
                    state_q    <= (RD_LATENCY == 1) ? ST_CMP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_W'(RD_LATENCY - 2)) state_q <= ST_CMP;
                    else wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                ST_CMP: begin
                    rsp_hit_q   <= sel_hit;
                    rsp_way_q   <= sel_way;
                    rsp_state_q <= sel_state;
                    evict0_q    <= mem_rd_data_evict_way[0];
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        upd_ready_q <= 1'b1;
                        state_q     <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    if (upd_valid) begin
                        if (upd_we) begin
                            mem_wr_en_q  <= 1'b1;
                            wr_addr_q    <= {set_q, upd_way};
                            wr_line_q    <= upd_line;
                            wr_tag_q     <= upd_tag;
                            wr_sharers_q <= upd_sharers;
                            wr_owner_q   <= upd_owner;
                            wr_hprot_q   <= upd_hprot;
                            wr_dirty_q   <= upd_dirty_bit;
                            wr_evict_q   <= wr_evict_d;
                            wr_state_q   <= upd_state;
                        end
                        if (upd_last) begin
                            upd_ready_q <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    upd_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LLC_LOOKUP_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (rsp_valid_q && rsp_ready) begin
            if (rsp_hit_q && !(&stat_hits_q)) stat_hits_q <= stat_hits_q + 32'd1;
            if (!rsp_hit_q && !(&stat_misses_q)) stat_misses_q <= stat_misses_q + 32'd1;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

    assign req_ready             = req_ready_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_hit               = rsp_hit_q;
    assign rsp_way               = rsp_way_q;
    assign rsp_state             = rsp_state_q;
    assign upd_ready             = upd_ready_q;
    assign mem_rd_set            = set_q;
    assign mem_rd_en             = mem_rd_en_q;
    assign mem_wr_en             = mem_wr_en_q;
    assign mem_wr_addr           = wr_addr_q;
    assign mem_wr_data_line      = wr_line_q;
    assign mem_wr_data_tag       = wr_tag_q;
    assign mem_wr_data_sharers   = wr_sharers_q;
    assign mem_wr_data_owner     = wr_owner_q;
    assign mem_wr_data_hprot     = wr_hprot_q;
    assign mem_wr_data_dirty_bit = wr_dirty_q;
    assign mem_wr_data_evict_way = wr_evict_q;
    assign mem_wr_data_state     = wr_state_q;

endmodule

// File: tb/tb_llc_lookup_ctrl.sv
// Directed bench for llc_lookup_ctrl: a set-level memory model drives the read
// data, and a per-cycle checker compares handshakes, responses and writes.
module tb_llc_lookup_ctrl;
    import llc_lookup_ctrl_pkg::*;

    localparam int NW     = NUM_PORTS;
    localparam int RD_LAT = 1;

    typedef struct packed {
        llc_addr_t  addr;
        llc_tag_t   tag;
        line_t      line;
        llc_state_t state;
        sharers_t   sharers;
        owner_t     owner;
        hprot_t     hprot;
        logic       dirty;
        llc_way_t   evict;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, rsp_ready = 1'b0, upd_valid = 1'b0, upd_we = 1'b0, upd_last = 1'b0;
    llc_set_t   req_set = '0;
    llc_tag_t   req_tag = '0;
    llc_way_t   upd_way = '0;
    llc_tag_t   upd_tag = '0;
    line_t      upd_line = '0;
    llc_state_t upd_state = '0;
    sharers_t   upd_sharers = '0;
    owner_t     upd_owner = '0;
    hprot_t     upd_hprot = '0;
    logic       upd_dirty_bit = 1'b0;

    logic req_ready, rsp_valid, rsp_hit, upd_ready, mem_rd_en, mem_wr_en, mem_wr_data_dirty_bit;
    llc_way_t   rsp_way, mem_wr_data_evict_way;
    llc_state_t rsp_state, mem_wr_data_state;
    llc_set_t   mem_rd_set;
    llc_addr_t  mem_wr_addr;
    line_t      mem_wr_data_line;
    llc_tag_t   mem_wr_data_tag;
    sharers_t   mem_wr_data_sharers;
    owner_t     mem_wr_data_owner;
    hprot_t     mem_wr_data_hprot;
`ifdef LLC_LOOKUP_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    llc_tag_t   rd_tag   [NW];
    llc_state_t rd_state [NW];
    llc_way_t   rd_evict [NW];

    // Backing store contents, indexed [set][way].
    llc_tag_t   mem_tag   [256][NW];
    llc_state_t mem_state [256][NW];
    llc_way_t   mem_evict [256][NW];

    llc_lookup_ctrl #(.NUM_WAYS(NW), .RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_state(rsp_state),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_we(upd_we), .upd_last(upd_last),
        .upd_way(upd_way), .upd_tag(upd_tag), .upd_line(upd_line), .upd_state(upd_state),
        .upd_sharers(upd_sharers), .upd_owner(upd_owner), .upd_hprot(upd_hprot),
        .upd_dirty_bit(upd_dirty_bit),
        .mem_rd_set(mem_rd_set), .mem_rd_en(mem_rd_en),
        .mem_rd_data_tag(rd_tag), .mem_rd_data_state(rd_state), .mem_rd_data_evict_way(rd_evict),
`ifdef LLC_LOOKUP_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
        .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en),
        .mem_wr_data_line(mem_wr_data_line), .mem_wr_data_tag(mem_wr_data_tag),
        .mem_wr_data_sharers(mem_wr_data_sharers), .mem_wr_data_owner(mem_wr_data_owner),
        .mem_wr_data_hprot(mem_wr_data_hprot), .mem_wr_data_dirty_bit(mem_wr_data_dirty_bit),
        .mem_wr_data_evict_way(mem_wr_data_evict_way), .mem_wr_data_state(mem_wr_data_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-cycle registered read port.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int w = 0; w < NW; w++) begin
                rd_tag[w]   <= mem_tag[mem_rd_set][w];
                rd_state[w] <= mem_state[mem_rd_set][w];
                rd_evict[w] <= mem_evict[mem_rd_set][w];
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Expected timeline and current-transaction model.
    bit  exp_rd [int];
    wr_t exp_wr [int];
    bit  busy = 1'b0, in_upd = 1'b0, rsp_pending = 1'b0;
    int  rsp_from = 0;
    llc_set_t   m_set = '0;
    logic       m_hit = 1'b0;
    llc_way_t   m_way = '0, m_evict0 = '0;
    llc_state_t m_state = '0;

    function automatic void model_lookup(input llc_set_t s, input llc_tag_t t);
        bit found;
        m_set    = s;
        m_hit    = 1'b0;
        m_evict0 = mem_evict[s][0];
        m_way    = m_evict0;
        for (int w = 0; w < NW; w++) begin
            if (!m_hit && mem_state[s][w] != INVALID && mem_tag[s][w] == t) begin
                m_hit = 1'b1;
                m_way = llc_way_t'(w);
            end
        end
        if (!m_hit) begin
            found = 1'b0;
            for (int w = 0; w < NW; w++) begin
                if (!found && mem_state[s][w] == INVALID) begin
                    found = 1'b1;
                    m_way = llc_way_t'(w);
                end
            end
        end
        m_state = mem_state[s][m_way];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 64'(req_ready), 64'(!busy));
            chk("upd_ready", 64'(upd_ready), 64'(in_upd));
            chk("mem_rd_en", 64'(mem_rd_en), 64'(exp_rd.exists(cyc) != 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(rsp_pending && cyc >= rsp_from));
            if (rsp_pending && cyc >= rsp_from) begin
                chk("rsp_hit", 64'(rsp_hit), 64'(m_hit));
                chk("rsp_way", 64'(rsp_way), 64'(m_way));
                chk("rsp_state", 64'(rsp_state), 64'(m_state));
                chk("mem_rd_set", 64'(mem_rd_set), 64'(m_set));
            end
            chk("mem_wr_en", 64'(mem_wr_en), 64'(exp_wr.exists(cyc) != 0));
            if (exp_wr.exists(cyc) && mem_wr_en) begin
                chk("wr_addr", 64'(mem_wr_addr), 64'(exp_wr[cyc].addr));
                chk("wr_tag", 64'(mem_wr_data_tag), 64'(exp_wr[cyc].tag));
                chk("wr_line", 64'(mem_wr_data_line), 64'(exp_wr[cyc].line));
                chk("wr_state", 64'(mem_wr_data_state), 64'(exp_wr[cyc].state));
                chk("wr_sharers", 64'(mem_wr_data_sharers), 64'(exp_wr[cyc].sharers));
                chk("wr_owner", 64'(mem_wr_data_owner), 64'(exp_wr[cyc].owner));
                chk("wr_hprot", 64'(mem_wr_data_hprot), 64'(exp_wr[cyc].hprot));
                chk("wr_dirty", 64'(mem_wr_data_dirty_bit), 64'(exp_wr[cyc].dirty));
                chk("wr_evict", 64'(mem_wr_data_evict_way), 64'(exp_wr[cyc].evict));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic lookup(input llc_set_t s, input llc_tag_t t, input int hold, input bit do_rst,
                          output logic hit, output llc_way_t way, output llc_state_t st);
        int c0;
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = t;
        c0        = cyc;
        exp_rd[c0 + 1] = 1'b1;
        model_lookup(s, t);
        rsp_from    = c0 + 2 + RD_LAT;
        rsp_pending = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy      = 1'b1;
        while (cyc < rsp_from + hold) begin
            @(posedge clk); #1;
        end
        hit = rsp_hit;
        way = rsp_way;
        st  = rsp_state;
        $display("lookup set=%0d tag=%h -> hit=%0d way=%0d state=%0d", s, t, hit, way, st);
        if (do_rst) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_resp_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_resp_wr_en", 64'(mem_wr_en), 64'd0);
            chk("rst_resp_req_ready", 64'(req_ready), 64'd1);
            rst         = 1'b0;
            busy        = 1'b0;
            rsp_pending = 1'b0;
        end else begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready   = 1'b0;
            rsp_pending = 1'b0;
            in_upd      = 1'b1;
        end
    endtask

    task automatic beat(input logic we, input logic last, input llc_way_t w);
        wr_t e;
        upd_valid     = 1'b1;
        upd_we        = we;
        upd_last      = last;
        upd_way       = w;
        upd_tag       = llc_tag_t'($urandom);
        upd_line      = {$urandom, $urandom};
        upd_state     = llc_state_t'($urandom_range(7, 0));
        upd_sharers   = sharers_t'($urandom);
        upd_owner     = owner_t'($urandom);
        upd_hprot     = hprot_t'($urandom);
        upd_dirty_bit = 1'($urandom);
        if (we) begin
            e.addr    = {m_set, w};
            e.tag     = upd_tag;
            e.line    = upd_line;
            e.state   = upd_state;
            e.sharers = upd_sharers;
            e.owner   = upd_owner;
            e.hprot   = upd_hprot;
            e.dirty   = upd_dirty_bit;
            e.evict   = (!m_hit && w == m_way) ? llc_way_t'((int'(m_way) + 1) % NW) : m_evict0;
            exp_wr[cyc + 1] = e;
        end
        $display("beat we=%0d last=%0d way=%0d", we, last, w);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        upd_we    = 1'b0;
        upd_last  = 1'b0;
        if (last) begin
            in_upd = 1'b0;
            busy   = 1'b0;
        end
    endtask

    task automatic fill_set(input llc_set_t s);
        for (int w = 0; w < NW; w++) begin
            mem_tag[s][w]   = llc_tag_t'(12'h100 + w);
            mem_state[s][w] = 3'd1;
            mem_evict[s][w] = '0;
        end
    endtask

    logic       r_hit;
    llc_way_t   r_way;
    llc_state_t r_st;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_set(8'd5);
        fill_set(8'd200);
        for (int w = 0; w < NW; w++) begin
            rd_tag[w] = '0; rd_state[w] = '0; rd_evict[w] = '0;
        end

        // Reset held for two edges.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_upd_ready", 64'(upd_ready), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_wr_line", 64'(mem_wr_data_line), 64'd0);
        chk("rst_rsp_way", 64'(rsp_way), 64'd0);
        chk("rst_rd_set", 64'(mem_rd_set), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hit on way 3.
        mem_tag[5][3] = 12'h1A2; mem_state[5][3] = 3'd2; mem_evict[5][0] = 4'd7;
        lookup(8'd5, 12'h1A2, 0, 1'b0, r_hit, r_way, r_st);
        chk("hit_hit", 64'(r_hit), 64'd1);
        chk("hit_way", 64'(r_way), 64'd3);
        chk("hit_state", 64'(r_st), 64'd2);
        beat(1'b1, 1'b1, 4'd3);
        chk("hit_wr_evict", 64'(mem_wr_data_evict_way), 64'd7);

        // Duplicate match: ways 2 and 6.
        fill_set(8'd5);
        mem_tag[5][2] = 12'h2B3; mem_tag[5][6] = 12'h2B3; mem_state[5][6] = 3'd5;
        lookup(8'd5, 12'h2B3, 1, 1'b0, r_hit, r_way, r_st);
        chk("dup_hit", 64'(r_hit), 64'd1);
        chk("dup_way", 64'(r_way), 64'd2);
        beat(1'b1, 1'b0, 4'd2);
        beat(1'b0, 1'b0, 4'd6);
        beat(1'b1, 1'b1, 4'd6);

        // Miss with way 4 invalid (its stale tag matches but must not hit).
        fill_set(8'd5);
        mem_state[5][4] = INVALID; mem_tag[5][4] = 12'h3C4; mem_evict[5][0] = 4'd9;
        lookup(8'd5, 12'h3C4, 0, 1'b0, r_hit, r_way, r_st);
        chk("inv_hit", 64'(r_hit), 64'd0);
        chk("inv_way", 64'(r_way), 64'd4);
        chk("inv_state", 64'(r_st), 64'd0);
        beat(1'b1, 1'b1, 4'd4);
        chk("inv_wr_evict", 64'(mem_wr_data_evict_way), 64'd5);

        // Eviction wrap at the last way.
        fill_set(8'd5);
        mem_evict[5][0] = 4'd15; mem_state[5][15] = 3'd3;
        lookup(8'd5, 12'h7FF, 0, 1'b0, r_hit, r_way, r_st);
        chk("wrap_hit", 64'(r_hit), 64'd0);
        chk("wrap_way", 64'(r_way), 64'd15);
        chk("wrap_state", 64'(r_st), 64'd3);
        beat(1'b1, 1'b0, 4'd7);
        chk("wrap_other_evict", 64'(mem_wr_data_evict_way), 64'd15);
        beat(1'b1, 1'b1, 4'd15);
        chk("wrap_wr_en", 64'(mem_wr_en), 64'd1);
        chk("wrap_wr_addr", 64'(mem_wr_addr), 64'h05F);
        chk("wrap_wr_evict", 64'(mem_wr_data_evict_way), 64'd0);

        // Reset while the response is pending.
        lookup(8'd5, 12'h105, 2, 1'b1, r_hit, r_way, r_st);
        chk("rstresp_model_way", 64'(r_way), 64'd5);
        @(posedge clk); #1;

        // Reset during UPD with a write beat presented: the write is dropped.
        mem_tag[200][9] = 12'hABC;
        lookup(8'd200, 12'hABC, 0, 1'b0, r_hit, r_way, r_st);
        chk("s200_way", 64'(r_way), 64'd9);
        rst = 1'b1; upd_valid = 1'b1; upd_we = 1'b1; upd_way = 4'd1;
        @(posedge clk); #1;
        chk("rstupd_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rstupd_upd_ready", 64'(upd_ready), 64'd0);
        chk("rstupd_req_ready", 64'(req_ready), 64'd1);
        rst = 1'b0; upd_valid = 1'b0; upd_we = 1'b0;
        in_upd = 1'b0; busy = 1'b0;
        @(posedge clk); #1;

        // Recovery: held response, then a write.
        lookup(8'd200, 12'hABC, 3, 1'b0, r_hit, r_way, r_st);
        chk("recov_hit", 64'(r_hit), 64'd1);
        beat(1'b1, 1'b1, 4'd9);
        chk("recov_wr_addr", 64'(mem_wr_addr), 64'hC89);
        repeat (3) begin
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
